// File: rtl/preg_free_arbiter_pkg.sv
// preg_free_arbiter_pkg: shared tag width and grant-source encoding for the free-list return arbiter
package preg_free_arbiter_pkg;
    localparam int PREG_W = 7;
    typedef enum logic {SRC_CMT, SRC_SQ} src_e;
endpackage

// File: rtl/preg_fifo.sv
// preg_fifo: circular-buffer FIFO of physical register tags with an explicit occupancy count
module preg_fifo #(
    parameter int DEPTH  = 4,
    parameter int PREG_W = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [PREG_W-1:0]        din,
    input  logic                     pop,
    output logic [PREG_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [PREG_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/preg_free_arbiter.sv
// preg_free_arbiter: round-robin merge of ROB commit and squash-walk tag returns onto the
// free list's single registered write port
module preg_free_arbiter #(
    parameter int DEPTH  = 4,
    parameter int PREG_W = 7
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmt_valid,
    input  logic [PREG_W-1:0]           cmt_preg,
    output logic                        cmt_ready,
    input  logic                        sq_valid,
    input  logic [PREG_W-1:0]           sq_preg,
    output logic                        sq_ready,
    input  logic                        fl_hold,
    output logic                        fl_write_en,
    output logic [PREG_W-1:0]           fl_data,
    output logic [$clog2(2*DEPTH):0]    pending
);
    import preg_free_arbiter_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(2*DEPTH) + 1;

    logic              cmt_push, sq_push;
    logic              cmt_full, sq_full;
    logic              cmt_empty, sq_empty;
    logic [PREG_W-1:0] cmt_head, sq_head;
    logic [CW-1:0]     cmt_count, sq_count;
    logic              gnt_cmt, gnt_sq;
    src_e              last_grant;

    assign cmt_ready = !cmt_full;
    assign sq_ready  = !sq_full;
    // Tag 0 is never a freeable register: handshake completes but nothing is queued
    assign cmt_push  = cmt_valid && cmt_ready && (cmt_preg != '0);
    assign sq_push   = sq_valid && sq_ready && (sq_preg != '0);

    assign gnt_cmt = !fl_hold && !cmt_empty && (sq_empty || last_grant == SRC_SQ);
    assign gnt_sq  = !fl_hold && !sq_empty && (cmt_empty || last_grant == SRC_CMT);
    assign pending = PW'(cmt_count) + PW'(sq_count);

    preg_fifo #(.DEPTH(DEPTH), .PREG_W(PREG_W)) u_cmt_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmt_push),
        .din   (cmt_preg),
        .pop   (gnt_cmt),
        .head  (cmt_head),
        .full  (cmt_full),
        .empty (cmt_empty),
        .count (cmt_count)
    );

    preg_fifo #(.DEPTH(DEPTH), .PREG_W(PREG_W)) u_sq_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (sq_push),
        .din   (sq_preg),
        .pop   (gnt_sq),
        .head  (sq_head),
        .full  (sq_full),
        .empty (sq_empty),
        .count (sq_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant  <= SRC_SQ;
            fl_write_en <= 1'b0;
            fl_data     <= '0;
        end else begin
            fl_write_en <= gnt_cmt || gnt_sq;
            if (gnt_cmt || gnt_sq) begin
                fl_data    <= gnt_cmt ? cmt_head : sq_head;
                last_grant <= gnt_cmt ? SRC_CMT : SRC_SQ;
            end
        end
    end
endmodule

// File: tb/tb_preg_free_arbiter.sv
// tb_preg_free_arbiter: queue-based reference model checked every cycle plus directed tag sequences
module tb_preg_free_arbiter;
    localparam int DEPTH  = 4;
    localparam int PREG_W = 7;
    localparam int PW     = $clog2(2*DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmt_valid = 1'b0;
    logic [PREG_W-1:0] cmt_preg = '0;
    logic              sq_valid = 1'b0;
    logic [PREG_W-1:0] sq_preg = '0;
    logic              fl_hold = 1'b0;
    logic              cmt_ready, sq_ready, fl_write_en;
    logic [PREG_W-1:0] fl_data;
    logic [PW-1:0]     pending;

    int n_cmp = 0;
    int n_bad = 0;
    int cq[$];
    int sqq[$];
    int seen[$];
    int exp_q[$];
    bit m_last_sq = 1'b1;
    bit m_we = 1'b0;
    int m_data = 0;
    bit ca, sa;

    preg_free_arbiter #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmt_valid   (cmt_valid),
        .cmt_preg    (cmt_preg),
        .cmt_ready   (cmt_ready),
        .sq_valid    (sq_valid),
        .sq_preg     (sq_preg),
        .sq_ready    (sq_ready),
        .fl_hold     (fl_hold),
        .fl_write_en (fl_write_en),
        .fl_data     (fl_data),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_seq(input string name, input int s[$], input int e[$]);
        chk({name, "_len"}, s.size(), e.size());
        for (int i = 0; i < e.size(); i++) chk(name, (i < s.size()) ? s[i] : -1, e[i]);
    endtask

    task automatic drive(input bit cv, input int cp, input bit sv, input int sp, input bit h);
        @(negedge clk);
        cmt_valid = cv;
        cmt_preg  = PREG_W'(cp);
        sq_valid  = sv;
        sq_preg   = PREG_W'(sp);
        fl_hold   = h;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0);
    endtask

    // Reference: two tag queues, alternate on ties, pop before push, zero tags dropped
    always @(posedge clk) begin
        if (!reset) begin
            cq.delete();
            sqq.delete();
            m_last_sq = 1'b1;
            m_we = 1'b0;
            m_data = 0;
        end else begin
            ca = cmt_valid && cq.size() < DEPTH && cmt_preg != 0;
            sa = sq_valid && sqq.size() < DEPTH && sq_preg != 0;
            m_we = 1'b0;
            if (!fl_hold) begin
                if (cq.size() > 0 && (sqq.size() == 0 || m_last_sq)) begin
                    m_data = cq.pop_front();
                    m_we = 1'b1;
                    m_last_sq = 1'b0;
                end else if (sqq.size() > 0) begin
                    m_data = sqq.pop_front();
                    m_we = 1'b1;
                    m_last_sq = 1'b1;
                end
            end
            if (ca) cq.push_back(int'(cmt_preg));
            if (sa) sqq.push_back(int'(sq_preg));
        end
        #1;
        chk("write_en", fl_write_en, m_we);
        chk("data", fl_data, m_data);
        chk("pending", pending, cq.size() + sqq.size());
        chk("cmt_ready", cmt_ready, cq.size() < DEPTH);
        chk("sq_ready", sq_ready, sqq.size() < DEPTH);
        if (fl_write_en) seen.push_back(int'(fl_data));
    end

    initial begin
        #2;
        chk("rst_we", fl_write_en, 0);
        chk("rst_pending", pending, 0);
        chk("rst_data", fl_data, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_cmt_ready", cmt_ready, 1);
        chk("rst_sq_ready", sq_ready, 1);

        // Tie round-robin: commit wins the first tie after reset
        seen.delete();
        drive(1, 33, 1, 50, 1);
        drive(1, 34, 1, 51, 1);
        idle(6);
        exp_q = '{33, 50, 34, 51};
        chk_seq("tie", seen, exp_q);

        // Single commit latency
        seen.delete();
        drive(1, 40, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("single_pend1", pending, 1);
        chk("single_we0", fl_write_en, 0);
        drive(0, 0, 0, 0, 0);
        chk("single_we1", fl_write_en, 1);
        chk("single_data", fl_data, 40);
        chk("single_pend0", pending, 0);
        idle(3);
        exp_q = '{40};
        chk_seq("single", seen, exp_q);

        // Zero tag filter
        seen.delete();
        drive(1, 0, 0, 0, 0);
        #1 chk("zero_ready", cmt_ready, 1);
        idle(4);
        chk("zero_pending", pending, 0);
        chk("zero_writes", seen.size(), 0);

        // Squash FIFO full under hold
        seen.delete();
        for (int i = 60; i < 64; i++) drive(0, 0, 1, i, 1);
        drive(0, 0, 1, 64, 1);
        chk("full_sq_ready", sq_ready, 0);
        chk("full_pending", pending, 4);
        drive(0, 0, 0, 0, 1);
        idle(7);
        exp_q = '{60, 61, 62, 63};
        chk_seq("full", seen, exp_q);

        // One-cycle hold during a drain
        seen.delete();
        for (int i = 10; i < 13; i++) drive(1, i, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        idle(5);
        exp_q = '{10, 11, 12};
        chk_seq("hold_mid", seen, exp_q);

        // Both full, long hold with offers still pending
        seen.delete();
        for (int i = 0; i < 4; i++) drive(1, 70 + i, 1, 80 + i, 1);
        repeat (20) drive(1, 99, 1, 98, 1);
        chk("both_cmt_ready", cmt_ready, 0);
        chk("both_sq_ready", sq_ready, 0);
        chk("both_pending", pending, 8);
        idle(11);
        exp_q = '{80, 70, 81, 71, 82, 72, 83, 73};
        chk_seq("both_full", seen, exp_q);

        // Pointer wrap-around with streaming push/pop
        seen.delete();
        for (int i = 1; i <= 2*DEPTH + 1; i++) drive(1, i, 0, 0, 0);
        idle(4);
        exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        chk_seq("wrap", seen, exp_q);

        // Asynchronous reset mid-drain
        for (int i = 20; i < 24; i++) drive(1, i, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("arst_pre_pending", pending, 3);
        chk("arst_pre_we", fl_write_en, 1);
        reset = 1'b0;
        #1;
        chk("arst_we", fl_write_en, 0);
        chk("arst_pending", pending, 0);
        chk("arst_data", fl_data, 0);
        seen.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(6);
        chk("arst_no_stale", seen.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/preg_free_arbiter.md
Name: preg_free_arbiter

Overview:
- Shares the free list's single return port (write_en, 7-bit data_in) between two requesters:
  - ROB commit, which returns pd_old of retiring instructions.
  - Mispredict squash walk, which returns pd_new of squashed instructions.
- Each source gets a small FIFO. A round-robin grant picks one entry per cycle and drives a registered write toward free_list.
- Sits between the ROB and rename's free_list, replacing the ROB's direct write_en/rob_data_in connection.

Parameters:
- DEPTH, 4, entries per source FIFO (power of two, ≥2).
- PREG_W, 7, physical register tag width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; state is cleared while reset == 0.
- cmt_valid  in  1  commit source offers a tag.
- cmt_preg  in  PREG_W  pd_old from the retiring ROB entry.
- cmt_ready  out  1  commit FIFO can accept.
- sq_valid  in  1  squash source offers a tag.
- sq_preg  in  PREG_W  pd_new from the squashed ROB entry.
- sq_ready  out  1  squash FIFO can accept.
- fl_hold  in  1  free list is restoring a checkpoint (mispredict cycle); no write may issue.
- fl_write_en  out  1  write strobe to free_list.
- fl_data  out  PREG_W  tag returned to free_list.
- pending  out  $clog2(2*DEPTH)+1  total entries held in both FIFOs.

Behaviour:
- Reset (reset == 0, asynchronous):
  - Both FIFOs empty; pointers and counts are 0.
  - last_grant = squash, so commit wins the first tie.
  - fl_write_en = 0, fl_data = 0, pending = 0.
  - cmt_ready = sq_ready = 1 once reset deasserts.
  - Reset asserted mid-operation discards all queued tags.
- Accept:
  - A source accepts on a rising edge when valid && ready.
  - x_ready = !full of that FIFO, from registered count only. There is no same-cycle pop-through, so a full FIFO deasserts ready even in a cycle where it is popped.
- Tag 0 filter: an accepted tag equal to 0 completes the handshake but is not stored, and does not change pending.
- Grant (combinational from FIFO state, evaluated each cycle):
  - If fl_hold == 1: no grant; FIFOs and last_grant hold.
  - Else if exactly one FIFO is non-empty: that FIFO is granted.
  - Else if both are non-empty: the source opposite last_grant is granted.
  - Else: no grant.
- Pop and output:
  - On a grant, the head of the granted FIFO is popped at the edge and last_grant is updated.
  - fl_write_en <= 1 and fl_data <= head at the same edge. When there is no grant, fl_write_en <= 0 and fl_data holds its value.
- Latency: tag accepted at edge E0 into an empty FIFO → earliest grant in cycle E0..E1 → fl_write_en high in cycle after E1. Throughput is 1 tag/cycle total.
- FIFOs:
  - Circular buffer, log2(DEPTH)-bit pointers wrapping modulo DEPTH.
  - Separate count register 0..DEPTH.
  - Push and pop of the same FIFO on the same edge is legal when not full; count is unchanged.
- Pending: pending = cmt_count + sq_count, registered, updated on the same edge as pushes and pops.
- Boundary conditions:
  - Both FIFOs full and fl_hold == 1 for many cycles: both readys stay 0, and nothing is lost or duplicated.
  - fl_hold asserted in the same cycle as a push: the push still succeeds.
  - Wrap-around: 2*DEPTH+1 sequential pushes and pops keep FIFO order.

Decomposition:
- Add to types_pkg:
  - PREG_W.
  - An enum src_e {SRC_CMT, SRC_SQ} used for last_grant.
- One sub-module, preg_fifo (DEPTH, PREG_W; push/pop/head/full/empty/count), instantiated twice.
- Grant logic and output register stay in the top module.

Test Plan:
- Single commit: cmt_preg=7'd40 accepted at E0 → fl_write_en=1, fl_data=40 exactly one cycle after E1; pending goes 1 then 0.
- Tie round-robin: preload cmt {33,34}, sq {50,51}, then release fl_hold → fl_data sequence 33,50,34,51 on four consecutive cycles.
- Zero filter: cmt_preg=0 with cmt_valid=1 → cmt_ready=1, pending stays 0, fl_write_en never pulses.
- Full/backpressure: fl_hold=1, push 4 squash tags 60..63 → sq_ready=0 after the 4th, pending=4; a 5th offer is not accepted; release fl_hold → 60,61,62,63 emitted in order, and sq_ready=1 again the cycle after the first pop.
- Hold mid-stream: fl_hold pulses one cycle during a drain of {10,11,12} → exactly one bubble in fl_write_en, all three tags emitted once each.
- Async reset: drive reset=0 mid-drain with pending=3 → fl_write_en=0, pending=0 immediately (no clock edge needed), and no stale tags after reset=1.
